// File: rtl/vr_pkg.sv
// Shared VR definitions: message type encoding and default field widths.
package vr_pkg;

  localparam int unsigned REPLICA_W_DEF = 4;
  localparam int unsigned VIEW_W_DEF    = 64;
  localparam int unsigned MSG_TYPE_W    = 2;

  typedef enum logic [MSG_TYPE_W-1:0] {
    MsgStartViewChange = 2'd0,
    MsgDoViewChange    = 2'd1,
    MsgStartView       = 2'd2
  } msg_type_e;

endpackage

// File: rtl/vr_bcast_dst_iter.sv
// Combinational peer iterator: walks replica indices 0..NUM_REPLICAS-1, skipping self.
module vr_bcast_dst_iter import vr_pkg::*; #(
  parameter int unsigned NUM_REPLICAS = 3,
  parameter int unsigned REPLICA_W    = REPLICA_W_DEF
) (
  input  logic [REPLICA_W-1:0] cur,
  input  logic [REPLICA_W-1:0] self_idx,
  output logic [REPLICA_W-1:0] first_dst,
  output logic [REPLICA_W-1:0] next_dst,
  output logic                 is_last,
  output logic                 none
);

  // Two spare bits so cur+2 and NUM_REPLICAS=16 never overflow the compare.
  localparam int unsigned IW = REPLICA_W + 2;
  localparam logic [IW-1:0] NumX = IW'(NUM_REPLICAS);

  logic [IW-1:0] cur_x;
  logic [IW-1:0] self_x;
  logic [IW-1:0] first_x;
  logic [IW-1:0] next_x;

  always_comb begin
    cur_x   = IW'(cur);
    self_x  = IW'(self_idx);
    first_x = (self_x == '0) ? IW'(1) : '0;
    next_x  = cur_x + IW'(1);
    if (next_x == self_x) begin
      next_x = cur_x + IW'(2);
    end
    none      = (first_x >= NumX);
    is_last   = (next_x >= NumX);
    first_dst = first_x[REPLICA_W-1:0];
    next_dst  = next_x[REPLICA_W-1:0];
  end

endmodule

// File: rtl/vr_bcast_sched.sv
// VR broadcast scheduler: fans one broadcast out into per-peer send headers with bounded
// in-flight sends. Optional statistics counters are enabled by defining VR_BCAST_STATS_EN.
module vr_bcast_sched import vr_pkg::*; #(
  parameter int unsigned NUM_REPLICAS    = 3,
  parameter int unsigned REPLICA_W       = REPLICA_W_DEF,
  parameter int unsigned VIEW_W          = VIEW_W_DEF,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bcast_req_val,
  output logic                  bcast_req_rdy,
  input  logic [MSG_TYPE_W-1:0] bcast_req_msg_type,
  input  logic [VIEW_W-1:0]     bcast_req_view,
  input  logic [REPLICA_W-1:0]  bcast_req_self_idx,
  output logic                  bcast_done,
  output logic                  send_hdr_val,
  input  logic                  send_hdr_rdy,
  output logic [REPLICA_W-1:0]  send_hdr_dst,
  output logic [MSG_TYPE_W-1:0] send_hdr_msg_type,
  output logic [VIEW_W-1:0]     send_hdr_view,
  input  logic                  send_cmp_val,
  output logic                  send_cmp_rdy
`ifdef VR_BCAST_STATS_EN
  ,
  output logic [31:0]           stat_bcast_cnt,
  output logic [31:0]           stat_send_cnt
`endif
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CntW-1:0] OutMax = CntW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic [REPLICA_W-1:0]   dst_q, dst_d;
  logic [REPLICA_W-1:0]   self_q, self_d;
  logic [MSG_TYPE_W-1:0]  msg_type_q, msg_type_d;
  logic [VIEW_W-1:0]      view_q, view_d;
  logic [CntW-1:0]        out_q, out_d;
  // Holds request/completion ready low until the first clock after reset release.
  logic                   live_q;

  logic                   hdr_fire;
  logic                   cmp_fire;
  logic [REPLICA_W-1:0]   it_self;
  logic [REPLICA_W-1:0]   it_first;
  logic [REPLICA_W-1:0]   it_next;
  logic                   it_last;
  logic                   it_none;

  // In IDLE the iterator looks at the incoming self index to pick the first peer.
  assign it_self = (state_q == StIdle) ? bcast_req_self_idx : self_q;

  vr_bcast_dst_iter #(
    .NUM_REPLICAS (NUM_REPLICAS),
    .REPLICA_W    (REPLICA_W)
  ) u_dst_iter (
    .cur       (dst_q),
    .self_idx  (it_self),
    .first_dst (it_first),
    .next_dst  (it_next),
    .is_last   (it_last),
    .none      (it_none)
  );

  assign send_hdr_val      = (state_q == StIssue) && (out_q < OutMax);
  assign hdr_fire          = send_hdr_val && send_hdr_rdy;
  assign send_cmp_rdy      = live_q;
  assign cmp_fire          = send_cmp_val && live_q && (out_q != '0);
  assign send_hdr_dst      = dst_q;
  assign send_hdr_msg_type = msg_type_q;
  assign send_hdr_view     = view_q;

  always_comb begin
    state_d       = state_q;
    dst_d         = dst_q;
    self_d        = self_q;
    msg_type_d    = msg_type_q;
    view_d        = view_q;
    bcast_req_rdy = 1'b0;
    bcast_done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        bcast_req_rdy = live_q;
        if (bcast_req_val && live_q) begin
          self_d     = bcast_req_self_idx;
          msg_type_d = bcast_req_msg_type;
          view_d     = bcast_req_view;
          dst_d      = it_first;
          state_d    = it_none ? StDone : StIssue;
        end
      end
      StIssue: begin
        if (hdr_fire) begin
          if (it_last) begin
            state_d = StDrain;
          end else begin
            dst_d = it_next;
          end
        end
      end
      StDrain: begin
        if (out_q == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        bcast_done = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_d = out_q;
    unique case ({hdr_fire, cmp_fire})
      2'b10:   out_d = out_q + CntW'(1);
      2'b01:   out_d = out_q - CntW'(1);
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      dst_q      <= '0;
      self_q     <= '0;
      msg_type_q <= '0;
      view_q     <= '0;
      out_q      <= '0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dst_q      <= dst_d;
      self_q     <= self_d;
      msg_type_q <= msg_type_d;
      view_q     <= view_d;
      out_q      <= out_d;
      live_q     <= 1'b1;
    end
  end

`ifdef VR_BCAST_STATS_EN
  logic [31:0] bcast_cnt_q;
  logic [31:0] send_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcast_cnt_q <= '0;
      send_cnt_q  <= '0;
    end else begin
      if (state_q == StDone) begin
        bcast_cnt_q <= bcast_cnt_q + 32'd1;
      end
      if (hdr_fire) begin
        send_cnt_q <= send_cnt_q + 32'd1;
      end
    end
  end

  assign stat_bcast_cnt = bcast_cnt_q;
  assign stat_send_cnt  = send_cnt_q;
`endif

endmodule

// File: tb/tb_vr_bcast_sched.sv
// Bench for vr_bcast_sched: three instances (N=3, N=5, N=1) sharing stimulus, table plus
// hand-written sequences. Stats checks are active when VR_BCAST_STATS_EN is defined.
module tb_vr_bcast_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_val [3];
  logic [1:0]  msg_type;
  logic [63:0] view_in;
  logic [3:0]  self_idx;
  logic        hdr_rdy;
  logic        cmp_val;

  logic        req_rdy  [3];
  logic        done_o   [3];
  logic        hdr_val  [3];
  logic [3:0]  hdr_dst  [3];
  logic [1:0]  hdr_mt   [3];
  logic [63:0] hdr_view [3];
  logic        cmp_rdy  [3];
`ifdef VR_BCAST_STATS_EN
  logic [31:0] st_b [3];
  logic [31:0] st_s [3];
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned NR = (g == 0) ? 3 : ((g == 1) ? 5 : 1);
    vr_bcast_sched #(
      .NUM_REPLICAS    (NR),
      .REPLICA_W       (4),
      .VIEW_W          (64),
      .MAX_OUTSTANDING (2)
    ) u_dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .bcast_req_val      (req_val[g]),
      .bcast_req_rdy      (req_rdy[g]),
      .bcast_req_msg_type (msg_type),
      .bcast_req_view     (view_in),
      .bcast_req_self_idx (self_idx),
      .bcast_done         (done_o[g]),
      .send_hdr_val       (hdr_val[g]),
      .send_hdr_rdy       (hdr_rdy),
      .send_hdr_dst       (hdr_dst[g]),
      .send_hdr_msg_type  (hdr_mt[g]),
      .send_hdr_view      (hdr_view[g]),
      .send_cmp_val       (cmp_val),
      .send_cmp_rdy       (cmp_rdy[g])
`ifdef VR_BCAST_STATS_EN
      ,
      .stat_bcast_cnt     (st_b[g]),
      .stat_send_cnt      (st_s[g])
`endif
    );
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after acceptance.
  task automatic start(input int k, input logic [3:0] s, input logic [1:0] mt,
                       input logic [63:0] v);
    int w = 0;
    while (!req_rdy[k] && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("req_rdy_before_accept", 64'(req_rdy[k]), 64'd1);
    self_idx   = s;
    msg_type   = mt;
    view_in    = v;
    req_val[k] = 1'b1;
    @(negedge clk);
    req_val[k] = 1'b0;
  endtask

  // Runs until bcast_done has pulsed and dropped; cmp follows each hdr by one cycle, or is
  // held high throughout when always_cmp is set.
  task automatic drain_loop(input int k, input bit always_cmp, input logic [1:0] mt,
                            input logic [63:0] v, output int nhdr,
                            output logic [15:0][3:0] dsts, output int ndone,
                            output int first_hdr, output int first_done);
    bit prev = 1'b0;
    bit fire;
    nhdr = 0; ndone = 0; dsts = '0; first_hdr = -1; first_done = -1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (done_o[k]) begin
        ndone++;
        if (first_done < 0) first_done = cyc;
      end else if (ndone > 0) begin
        break;
      end
      fire = hdr_val[k] && hdr_rdy;
      if (fire) begin
        if (nhdr < 16) dsts[nhdr] = hdr_dst[k];
        nhdr++;
        if (first_hdr < 0) first_hdr = cyc;
        check("hdr_msg_type", 64'(hdr_mt[k]), 64'(mt));
        check("hdr_view", hdr_view[k], v);
      end
      cmp_val = always_cmp | prev;
      prev = fire;
      @(negedge clk);
    end
    cmp_val = 1'b0;
  endtask

  typedef struct {
    int          k;
    logic [3:0]  self_i;
    logic [1:0]  mt;
    logic [63:0] view;
    int          exp_n;
    logic [63:0] exp_dsts;
  } vec_t;

  vec_t vecs [8];

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int nhdr, ndone, fh, fd, cnt;
    logic [15:0][3:0] dsts;

    vecs[0] = '{0, 4'd1, 2'd0, 64'h1, 2, 64'h20};
    vecs[1] = '{0, 4'd0, 2'd1, 64'hDEAD_BEEF_0000_0002, 2, 64'h21};
    vecs[2] = '{0, 4'd3, 2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 3, 64'h210};
    vecs[3] = '{1, 4'd0, 2'd0, 64'h5, 4, 64'h4321};
    vecs[4] = '{1, 4'd2, 2'd1, 64'h8000_0000_0000_0000, 4, 64'h4310};
    vecs[5] = '{1, 4'd4, 2'd2, 64'h7, 4, 64'h3210};
    vecs[6] = '{1, 4'd7, 2'd0, 64'h9, 5, 64'h43210};
    vecs[7] = '{0, 4'd2, 2'd1, 64'h3, 2, 64'h10};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) req_val[i] = 1'b0;
    msg_type = '0; view_in = '0; self_idx = '0; hdr_rdy = 1'b0; cmp_val = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_req_rdy", 64'(req_rdy[i]), 64'd0);
      check("reset_hdr_val", 64'(hdr_val[i]), 64'd0);
      check("reset_done", 64'(done_o[i]), 64'd0);
      check("reset_cmp_rdy", 64'(cmp_rdy[i]), 64'd0);
    end
    rst_n = 1'b1;
    #1;
    check("release_req_rdy_low", 64'(req_rdy[0]), 64'd0);
    @(negedge clk);
    check("release_req_rdy_high", 64'(req_rdy[0]), 64'd1);
    check("release_cmp_rdy_high", 64'(cmp_rdy[1]), 64'd1);

    // Table: rdy=1, cmp one cycle after each hdr
    hdr_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      start(vecs[i].k, vecs[i].self_i, vecs[i].mt, vecs[i].view);
      drain_loop(vecs[i].k, 1'b0, vecs[i].mt, vecs[i].view, nhdr, dsts, ndone, fh, fd);
      check($sformatf("vec%0d_nhdr", i), 64'(nhdr), 64'(vecs[i].exp_n));
      check($sformatf("vec%0d_dsts", i), dsts, vecs[i].exp_dsts);
      check($sformatf("vec%0d_done_once", i), 64'(ndone), 64'd1);
      check($sformatf("vec%0d_first_hdr_lat", i), 64'(fh), 64'd0);
      check($sformatf("vec%0d_rdy_after", i), 64'(req_rdy[vecs[i].k]), 64'd1);
    end

    // Spurious completions while everything is idle
    cmp_val = 1'b1;
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) check("spurious_cmp_no_done", 64'(done_o[i]), 64'd0);
    end
    cmp_val = 1'b0;

    // N=5, self=0, completions withheld: exactly two hdrs then stall
    start(1, 4'd0, 2'd1, 64'h77);
    cnt = 0; dsts = '0;
    repeat (6) begin
      if (hdr_val[1] && hdr_rdy) begin
        dsts[cnt] = hdr_dst[1];
        cnt++;
      end
      @(negedge clk);
    end
    check("withheld_nhdr", 64'(cnt), 64'd2);
    check("withheld_dsts", dsts, 64'h21);
    check("withheld_val_low", 64'(hdr_val[1]), 64'd0);
    drain_loop(1, 1'b1, 2'd1, 64'h77, nhdr, dsts, ndone, fh, fd);
    check("resume_nhdr", 64'(nhdr), 64'd2);
    check("resume_dsts", dsts, 64'h43);
    check("resume_done", 64'(ndone), 64'd1);

    // Hdr handshake and cmp in the same cycle keep outstanding at 1
    start(1, 4'd0, 2'd2, 64'h99);
    check("same_c0_dst", 64'(hdr_dst[1]), 64'd1);
    @(negedge clk);
    check("same_c1_val", 64'(hdr_val[1]), 64'd1);
    check("same_c1_dst", 64'(hdr_dst[1]), 64'd2);
    cmp_val = 1'b1;
    @(negedge clk);
    cmp_val = 1'b0;
    check("same_c2_val", 64'(hdr_val[1]), 64'd1);
    check("same_c2_dst", 64'(hdr_dst[1]), 64'd3);
    @(negedge clk);
    check("same_c3_val_low", 64'(hdr_val[1]), 64'd0);
    drain_loop(1, 1'b1, 2'd2, 64'h99, nhdr, dsts, ndone, fh, fd);
    check("same_tail_nhdr", 64'(nhdr), 64'd1);
    check("same_tail_dsts", dsts, 64'h4);
    check("same_tail_done", 64'(ndone), 64'd1);

    // send_hdr_rdy held low for 10 cycles
    hdr_rdy = 1'b0;
    start(0, 4'd1, 2'd2, 64'hABCD_0123);
    for (int c = 0; c < 10; c++) begin
      check("stall_val", 64'(hdr_val[0]), 64'd1);
      check("stall_dst", 64'(hdr_dst[0]), 64'd0);
      check("stall_mt", 64'(hdr_mt[0]), 64'd2);
      check("stall_view", hdr_view[0], 64'hABCD_0123);
      @(negedge clk);
    end
    hdr_rdy = 1'b1;
    drain_loop(0, 1'b0, 2'd2, 64'hABCD_0123, nhdr, dsts, ndone, fh, fd);
    check("stall_nhdr", 64'(nhdr), 64'd2);
    check("stall_dsts", dsts, 64'h20);
    check("stall_done", 64'(ndone), 64'd1);
    check("stall_first_hdr", 64'(fh), 64'd0);

    // Reset mid-ISSUE after one of two sends
    start(0, 4'd1, 2'd1, 64'h55);
    check("rst_pre_dst0", 64'(hdr_dst[0]), 64'd0);
    @(negedge clk);
    check("rst_pre_dst2", 64'(hdr_dst[0]), 64'd2);
    hdr_rdy = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_hdr_val", 64'(hdr_val[0]), 64'd0);
    check("rst_mid_dst", 64'(hdr_dst[0]), 64'd0);
    check("rst_mid_mt", 64'(hdr_mt[0]), 64'd0);
    check("rst_mid_view", hdr_view[0], 64'd0);
    check("rst_mid_req_rdy", 64'(req_rdy[0]), 64'd0);
    check("rst_mid_cmp_rdy", 64'(cmp_rdy[0]), 64'd0);
    check("rst_mid_done", 64'(done_o[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel_req_rdy_low", 64'(req_rdy[0]), 64'd0);
    @(negedge clk);
    check("rst_rel_req_rdy_high", 64'(req_rdy[0]), 64'd1);
    cmp_val = 1'b1;
    @(negedge clk);
    cmp_val = 1'b0;
    check("rst_late_cmp_no_done_a", 64'(done_o[0]), 64'd0);
    @(negedge clk);
    check("rst_late_cmp_no_done_b", 64'(done_o[0]), 64'd0);
    hdr_rdy = 1'b1;
    start(0, 4'd1, 2'd0, 64'h66);
    drain_loop(0, 1'b0, 2'd0, 64'h66, nhdr, dsts, ndone, fh, fd);
    check("rst_after_nhdr", 64'(nhdr), 64'd2);
    check("rst_after_dsts", dsts, 64'h20);
    check("rst_after_done", 64'(ndone), 64'd1);
`ifdef VR_BCAST_STATS_EN
    check("stat_n3_bcast", 64'(st_b[0]), 64'd1);
    check("stat_n3_send", 64'(st_s[0]), 64'd2);
`endif

    // N=1, self=0: no peers, done one cycle after accept
    start(2, 4'd0, 2'd2, 64'h11);
    drain_loop(2, 1'b0, 2'd2, 64'h11, nhdr, dsts, ndone, fh, fd);
    check("n1_nhdr", 64'(nhdr), 64'd0);
    check("n1_done", 64'(ndone), 64'd1);
    check("n1_done_lat", 64'(fd), 64'd0);
    check("n1_rdy_after", 64'(req_rdy[2]), 64'd1);
`ifdef VR_BCAST_STATS_EN
    check("stat_n1_bcast", 64'(st_b[2]), 64'd1);
    check("stat_n1_send", 64'(st_s[2]), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
